// File: rtl/axi4_lite_write_slave.sv
// AXI4-Lite write slave: joins AW and W beats, issues one masked
// memory write, and answers on B after a fixed latency.
module axi4_lite_write_slave #(
  parameter logic [63:0] BASE_ADDR     = 64'h0000_0000_8000_0000,
  parameter logic [63:0] MEM_SIZE      = 64'h0000_0000_0800_0000,
  parameter int          WRITE_LATENCY = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [63:0] AW_ADDR,
  input  logic        AW_VALID,
  output logic        AW_READY,
  input  logic [63:0] W_DATA,
  input  logic [7:0]  W_STRB,
  input  logic        W_VALID,
  output logic        W_READY,
  output logic [1:0]  B_RESP,
  output logic        B_VALID,
  input  logic        B_READY,
  output logic        MEM_WEN,
  output logic [63:0] MEM_WADDR,
  output logic [63:0] MEM_WDATA,
  output logic [7:0]  MEM_WMASK
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(WRITE_LATENCY - 1);
  localparam logic [1:0] OKAY     = 2'b00;
  localparam logic [1:0] DECERR   = 2'b11;

  state_e      state_q, state_d;
  logic        aw_got_q, aw_got_d;
  logic        w_got_q, w_got_d;
  logic        aw_ready_q, aw_ready_d;
  logic        w_ready_q, w_ready_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] data_q, data_d;
  logic [7:0]  strb_q, strb_d;
  logic        mem_wen_q, mem_wen_d;
  logic        dec_q, dec_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        b_valid_q, b_valid_d;
  logic [1:0]  b_resp_q, b_resp_d;

  logic        aw_hs;
  logic        w_hs;
  logic        hit;

  // Subtract before comparing so a window touching the top of the
  // address space cannot overflow.
  function automatic logic in_range(input logic [63:0] a);
    return (a >= BASE_ADDR) && ((a - BASE_ADDR) < MEM_SIZE);
  endfunction

  assign aw_hs = AW_VALID & aw_ready_q;
  assign w_hs  = W_VALID & w_ready_q;

  // Next-state logic for the channel join, write pulse and response.
  always_comb begin
    state_d    = state_q;
    aw_got_d   = aw_got_q;
    w_got_d    = w_got_q;
    aw_ready_d = aw_ready_q;
    w_ready_d  = w_ready_q;
    addr_d     = addr_q;
    data_d     = data_q;
    strb_d     = strb_q;
    mem_wen_d  = 1'b0;
    dec_d      = dec_q;
    cnt_d      = cnt_q;
    b_valid_d  = b_valid_q;
    b_resp_d   = b_resp_q;
    hit        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (aw_hs) begin
          addr_d   = AW_ADDR;
          aw_got_d = 1'b1;
        end
        if (w_hs) begin
          data_d  = W_DATA;
          strb_d  = W_STRB;
          w_got_d = 1'b1;
        end
        aw_ready_d = !aw_got_d;
        w_ready_d  = !w_got_d;
        if (aw_got_d && w_got_d) begin
          hit       = in_range(addr_d);
          state_d   = WRITE;
          mem_wen_d = hit;
          dec_d     = !hit;
          cnt_d     = CNT_INIT;
        end
      end
      WRITE: begin
        if (cnt_q == 4'd0) begin
          state_d   = RESP;
          b_valid_d = 1'b1;
          b_resp_d  = dec_q ? DECERR : OKAY;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (B_READY) begin
          state_d    = IDLE;
          b_valid_d  = 1'b0;
          b_resp_d   = OKAY;
          aw_got_d   = 1'b0;
          w_got_d    = 1'b0;
          aw_ready_d = 1'b1;
          w_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      strb_q     <= '0;
      mem_wen_q  <= 1'b0;
      dec_q      <= 1'b0;
      cnt_q      <= '0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= OKAY;
    end else begin
      state_q    <= state_d;
      aw_got_q   <= aw_got_d;
      w_got_q    <= w_got_d;
      aw_ready_q <= aw_ready_d;
      w_ready_q  <= w_ready_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      strb_q     <= strb_d;
      mem_wen_q  <= mem_wen_d;
      dec_q      <= dec_d;
      cnt_q      <= cnt_d;
      b_valid_q  <= b_valid_d;
      b_resp_q   <= b_resp_d;
    end
  end

  // A reset arriving in the write cycle must still suppress the strobe.
  assign MEM_WEN   = mem_wen_q & RST_N;
  assign MEM_WADDR = {addr_q[63:3], 3'b000};
  assign MEM_WDATA = data_q;
  assign MEM_WMASK = strb_q;
  assign AW_READY  = aw_ready_q;
  assign W_READY   = w_ready_q;
  assign B_VALID   = b_valid_q;
  assign B_RESP    = b_resp_q;

endmodule

// File: tb/tb_axi4_lite_write_slave.sv
// Scoreboard bench for axi4_lite_write_slave: a latency-1 instance
// driven by directed and randomly skewed writes, plus a latency-4 one.
module tb_axi4_lite_write_slave;

  logic        CLK = 1'b0;
  logic        RST_N;
  always #5 CLK = ~CLK;

  logic [63:0] aw_addr, w_data, mem_waddr, mem_wdata;
  logic        aw_valid, aw_ready, w_valid, w_ready;
  logic [7:0]  w_strb, mem_wmask;
  logic [1:0]  b_resp;
  logic        b_valid, b_ready, mem_wen;

  logic [63:0] aw_addr4, w_data4, mem_waddr4, mem_wdata4;
  logic        aw_valid4, aw_ready4, w_valid4, w_ready4;
  logic [7:0]  w_strb4, mem_wmask4;
  logic [1:0]  b_resp4;
  logic        b_valid4, b_ready4, mem_wen4;

  axi4_lite_write_slave u_dut (
    .CLK(CLK), .RST_N(RST_N),
    .AW_ADDR(aw_addr), .AW_VALID(aw_valid), .AW_READY(aw_ready),
    .W_DATA(w_data), .W_STRB(w_strb), .W_VALID(w_valid),
    .W_READY(w_ready), .B_RESP(b_resp), .B_VALID(b_valid),
    .B_READY(b_ready), .MEM_WEN(mem_wen), .MEM_WADDR(mem_waddr),
    .MEM_WDATA(mem_wdata), .MEM_WMASK(mem_wmask)
  );

  axi4_lite_write_slave #(.WRITE_LATENCY(4)) u_dut4 (
    .CLK(CLK), .RST_N(RST_N),
    .AW_ADDR(aw_addr4), .AW_VALID(aw_valid4), .AW_READY(aw_ready4),
    .W_DATA(w_data4), .W_STRB(w_strb4), .W_VALID(w_valid4),
    .W_READY(w_ready4), .B_RESP(b_resp4), .B_VALID(b_valid4),
    .B_READY(b_ready4), .MEM_WEN(mem_wen4), .MEM_WADDR(mem_waddr4),
    .MEM_WDATA(mem_wdata4), .MEM_WMASK(mem_wmask4)
  );

  typedef struct {
    logic [63:0] a;
    logic [63:0] d;
    logic [7:0]  m;
  } wr_t;

  wr_t        exp_wr[$];
  logic [1:0] exp_b[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int wen_n = 0;
  int exp_wen_n = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic push(input logic [63:0] a, input logic [63:0] d,
                      input logic [7:0] m, input logic ok);
    wr_t e;
    if (ok) begin
      e.a = a;
      e.d = d;
      e.m = m;
      exp_wr.push_back(e);
      exp_wen_n++;
      exp_b.push_back(2'b00);
    end else begin
      exp_b.push_back(2'b11);
    end
  endtask

  wr_t        mon_e;
  logic [1:0] mon_r;
  logic       wen_prev = 1'b0;
  logic       bv_prev = 1'b0;
  logic       br_prev = 1'b0;
  logic [1:0] resp_prev = 2'b00;
  int         wen_cyc = 0;

  // Monitor: pops expectations whenever the DUT shows a write or a
  // new response, and checks response stability during stalls.
  always @(negedge CLK) begin
    if (mem_wen) begin
      wen_n++;
      chk("wen_single_cycle", {63'd0, wen_prev}, 64'd0);
      if (exp_wr.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_wen: got addr %h expected none",
                 mem_waddr);
      end else begin
        mon_e = exp_wr.pop_front();
        chk("mem_waddr", mem_waddr, mon_e.a);
        chk("mem_wdata", mem_wdata, mon_e.d);
        chk("mem_wmask", {56'd0, mem_wmask}, {56'd0, mon_e.m});
      end
      wen_cyc = cyc;
    end
    if (b_valid && !bv_prev) begin
      if (exp_b.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_b: got resp %b expected none", b_resp);
      end else begin
        mon_r = exp_b.pop_front();
        chk("b_resp", {62'd0, b_resp}, {62'd0, mon_r});
        if (mon_r == 2'b00)
          chk("b_latency", 64'(cyc - wen_cyc), 64'd1);
      end
    end
    if (bv_prev && !br_prev) begin
      chk("b_valid_hold", {63'd0, b_valid}, 64'd1);
      chk("b_resp_hold", {62'd0, b_resp}, {62'd0, resp_prev});
    end
    wen_prev  <= mem_wen;
    bv_prev   <= b_valid;
    br_prev   <= b_ready;
    resp_prev <= b_resp;
  end

  // All driver tasks start and end at posedge + #1.
  task automatic send_aw(input logic [63:0] a, input int dly);
    logic hs;
    int n;
    repeat (dly) begin @(posedge CLK); #1; end
    aw_addr  = a;
    aw_valid = 1'b1;
    n = 0;
    do begin
      @(negedge CLK);
      hs = aw_ready;
      @(posedge CLK);
      #1;
      n++;
    end while (!hs && n < 100);
    chk("aw_handshake", {63'd0, hs}, 64'd1);
    aw_valid = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] d, input logic [7:0] s,
                        input int dly);
    logic hs;
    int n;
    repeat (dly) begin @(posedge CLK); #1; end
    w_data  = d;
    w_strb  = s;
    w_valid = 1'b1;
    n = 0;
    do begin
      @(negedge CLK);
      hs = w_ready;
      @(posedge CLK);
      #1;
      n++;
    end while (!hs && n < 100);
    chk("w_handshake", {63'd0, hs}, 64'd1);
    w_valid = 1'b0;
  endtask

  task automatic recv_b(input int dly, input logic hold);
    int n;
    n = 0;
    @(negedge CLK);
    while (!b_valid && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("b_seen", {63'd0, b_valid}, 64'd1);
    if (!hold) begin
      repeat (dly) @(negedge CLK);
      @(posedge CLK);
      #1;
      b_ready = 1'b1;
    end
    @(posedge CLK);
    #1;
    b_ready = 1'b0;
  endtask

  task automatic do_write(input logic [63:0] a, input logic [63:0] d,
                          input logic [7:0] s, input logic ok,
                          input int awd, input int wd, input int bd);
    push({a[63:3], 3'b000}, d, s, ok);
    fork
      send_aw(a, awd);
      send_w(d, s, wd);
    join
    recv_b(bd, 1'b0);
  endtask

  logic [63:0] ra, rd;
  logic [7:0]  rs;
  int          k;

  initial begin
    RST_N = 1'b0;
    {aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready} = '0;
    {aw_addr4, aw_valid4, w_data4, w_strb4, w_valid4, b_ready4} = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_aw_ready", {63'd0, aw_ready}, 64'd0);
    chk("rst_w_ready", {63'd0, w_ready}, 64'd0);
    chk("rst_b_valid", {63'd0, b_valid}, 64'd0);
    chk("rst_b_resp", {62'd0, b_resp}, 64'd0);
    chk("rst_mem_wen", {63'd0, mem_wen}, 64'd0);
    chk("rst_mem_waddr", mem_waddr, 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    chk("rst_mem_wmask", {56'd0, mem_wmask}, 64'd0);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    chk("post_rst_aw_ready", {63'd0, aw_ready}, 64'd1);
    chk("post_rst_w_ready", {63'd0, w_ready}, 64'd1);

    // Same-cycle AW and W with B_READY held high in advance.
    b_ready = 1'b1;
    push(64'h8000_0010, 64'hDEAD_BEEF_0123_4567, 8'hFF, 1'b1);
    fork
      send_aw(64'h8000_0010, 0);
      send_w(64'hDEAD_BEEF_0123_4567, 8'hFF, 0);
    join
    recv_b(0, 1'b1);
    chk("t1_aw_ready_back", {63'd0, aw_ready}, 64'd1);
    chk("t1_w_ready_back", {63'd0, w_ready}, 64'd1);

    // W first, misaligned AW three cycles later.
    push(64'h8000_0000, 64'h0102_0304_0506_0708, 8'h0F, 1'b1);
    send_w(64'h0102_0304_0506_0708, 8'h0F, 0);
    repeat (3) begin
      @(negedge CLK);
      chk("t2_w_ready_low", {63'd0, w_ready}, 64'd0);
    end
    @(posedge CLK);
    #1;
    send_aw(64'h8000_0007, 0);
    recv_b(0, 1'b0);

    // Window boundaries.
    do_write(64'h7FFF_FFF8, 64'h1111, 8'hFF, 1'b0, 0, 0, 0);
    do_write(64'h8800_0000, 64'h2222, 8'hFF, 1'b0, 1, 0, 1);
    do_write(64'h87FF_FFF8, 64'h3333, 8'h81, 1'b1, 0, 2, 0);

    // Zero strobe still writes.
    do_write(64'h8000_0040, 64'h4444, 8'h00, 1'b1, 0, 0, 0);

    // Reset right after both handshakes abandons the transaction.
    fork
      send_aw(64'h8000_0100, 0);
      send_w(64'h5555, 8'hFF, 0);
    join
    RST_N = 1'b0;
    @(negedge CLK);
    chk("t5_no_wen", {63'd0, mem_wen}, 64'd0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    chk("t5_aw_ready_rst", {63'd0, aw_ready}, 64'd0);
    chk("t5_w_ready_rst", {63'd0, w_ready}, 64'd0);
    chk("t5_b_valid_rst", {63'd0, b_valid}, 64'd0);
    @(posedge CLK);
    #1;
    chk("t5_aw_ready_rel", {63'd0, aw_ready}, 64'd1);
    chk("t5_w_ready_rel", {63'd0, w_ready}, 64'd1);
    repeat (8) @(posedge CLK);
    #1;
    chk("t5_no_b", {63'd0, b_valid}, 64'd0);

    // Back-to-back writes with random skew and response delay.
    for (int i = 0; i < 16; i++) begin
      ra = 64'h8000_0000 + 64'($urandom_range(0, 1023) << 3)
         + 64'($urandom_range(0, 7));
      rd = {$urandom, $urandom};
      rs = 8'($urandom_range(0, 255));
      do_write(ra, rd, rs, 1'b1, $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 4));
    end
    repeat (4) @(posedge CLK);
    #1;
    chk("wen_total", 64'(wen_n), 64'(exp_wen_n));
    chk("exp_wr_drained", 64'(exp_wr.size()), 64'd0);
    chk("exp_b_drained", 64'(exp_b.size()), 64'd0);

    // Latency-4 instance with a stalled response.
    @(negedge CLK);
    chk("l4_ready", {63'd0, aw_ready4 & w_ready4}, 64'd1);
    @(posedge CLK);
    #1;
    aw_addr4  = 64'h8000_0100;
    aw_valid4 = 1'b1;
    w_data4   = 64'h1122_3344_5566_7788;
    w_strb4   = 8'hF0;
    w_valid4  = 1'b1;
    @(posedge CLK);
    #1;
    aw_valid4 = 1'b0;
    w_valid4  = 1'b0;
    @(negedge CLK);
    chk("l4_wen", {63'd0, mem_wen4}, 64'd1);
    chk("l4_waddr", mem_waddr4, 64'h8000_0100);
    chk("l4_wmask", {56'd0, mem_wmask4}, 64'h0F0);
    k = 0;
    while (!b_valid4 && k < 20) begin
      @(negedge CLK);
      k++;
    end
    chk("l4_latency", 64'(k), 64'd4);
    aw_addr4  = 64'h8000_0200;
    aw_valid4 = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      chk("l4_b_valid_stall", {63'd0, b_valid4}, 64'd1);
      chk("l4_b_resp_stall", {62'd0, b_resp4}, 64'd0);
      chk("l4_aw_blocked", {63'd0, aw_ready4}, 64'd0);
    end
    @(posedge CLK);
    #1;
    b_ready4 = 1'b1;
    @(posedge CLK);
    #1;
    b_ready4 = 1'b0;
    chk("l4_b_drop", {63'd0, b_valid4}, 64'd0);
    chk("l4_aw_ready_back", {63'd0, aw_ready4}, 64'd1);
    chk("l4_w_ready_back", {63'd0, w_ready4}, 64'd1);
    @(posedge CLK);
    #1;
    aw_valid4 = 1'b0;
    chk("l4_second_aw_taken", {63'd0, aw_ready4}, 64'd0);
    chk("l4_w_still_ready", {63'd0, w_ready4}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
